column_scanner: RTL and testbench
=================================

# column_scanner

Parametrised successor to the column multiplexer. It drives the one-hot column select lines (`fpga_mul_a`/`fpga_mul_b`) from the driver controller's `column_ready` strobe, with the following features:
- configurable column count;
- guaranteed blanking dead time between columns, to prevent ghosting;
- forward and reverse scan direction;
- resynchronisation to column 0 on `position_sync`;
- an optional stall watchdog.

It sits between `driver_controller` and the mux pins in the top level.

## Interface

Parameters:
- `NB_COLUMNS`, 8: number of mux lines, ≥ 2.
- `BLANK_CYCLES`, 4: clk cycles all lines are off between two columns, ≥ 1.
- `WATCHDOG_CYCLES`, 2000000: maximum clk cycles a column may stay lit; used only with the watchdog.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `nrst` in 1: asynchronous, active-low reset.
- `column_ready` in 1: one-cycle strobe, advance to the next column.
- `position_sync` in 1: one-cycle strobe, restart at column 0.
- `scan_dir` in 1: 0 = increment, 1 = decrement; sampled when the next target is computed.
- `mux_out` out `NB_COLUMNS`: one-hot active-high column select, registered.
- `column_index` out `max(1,$clog2(NB_COLUMNS))`: index of the lit column; holds its value while blanked.
- `frame_done` out 1: one-cycle pulse on scan wrap-around.
- `overrun` out 1: sticky; `column_ready` arrived during blanking.
- `fault` out 1: sticky watchdog trip; tied 0 without the watchdog.

## Operation

States: IDLE, BLANK, ACTIVE, and FAULT (FAULT exists only with the watchdog).

Reset values: all outputs 0, state IDLE, internal target 0.

IDLE:
- `mux_out` = 0.
- `column_ready` or `position_sync` → target 0, load the blank counter, go to BLANK.

BLANK:
- `mux_out` = 0.
- The counter runs `BLANK_CYCLES` cycles. On expiry: `mux_out` = 1 << target, `column_index` = target, go to ACTIVE.
- `position_sync` in BLANK: target 0, blank counter reloaded (restarts full dead time).
- `column_ready` in BLANK: ignored, `overrun` set.

ACTIVE:
- `mux_out` is held.
- On `column_ready`, the next target is computed:
  - `scan_dir`=0: index+1, wrapping `NB_COLUMNS-1` → 0.
  - `scan_dir`=1: index−1, wrapping 0 → `NB_COLUMNS-1`.
  - If a wrap occurred, `frame_done` pulses.
  - Go to BLANK.
- On `position_sync`: target 0, go to BLANK, no `frame_done`.

Other rules:
- **Simultaneous `position_sync` and `column_ready`:** `position_sync` wins; `column_ready` is dropped and does not set `overrun`.
- **Clearing sticky flags:** `overrun` and `fault` clear only on `position_sync` (or reset).
- **Index arithmetic:** unsigned modulo `NB_COLUMNS`. It need not be a power of two, so the wrap is explicit, not bit truncation.
- **Invariant:** `mux_out` is never multi-hot, and is never non-zero outside ACTIVE.
- **Reset mid-operation:** `mux_out` goes to 0 immediately (asynchronously); the block restarts in IDLE.

## Timing

- **`column_ready` sampled high at edge t (ACTIVE):**
  - `mux_out` = 0 after edge t+1;
  - new one-hot after edge t+1+`BLANK_CYCLES`;
  - `frame_done` high for the single cycle after edge t+1.
- **Dead time:** exactly `BLANK_CYCLES` cycles of all-zero `mux_out`.
- **`column_index`:** updates in the same cycle `mux_out` turns on.
- **`position_sync` in any state:** same latency as above, targeting column 0.
- **Throughput:** at most one column change per `BLANK_CYCLES`+1 cycles. Faster strobes set `overrun`.

## Configuration

- **`COLUMN_SCANNER_WATCHDOG_EN` defined:**
  - An ACTIVE dwell counter is cleared on entry to ACTIVE.
  - Reaching `WATCHDOG_CYCLES` without `column_ready`/`position_sync` → FAULT: `mux_out` = 0, `fault` = 1.
  - FAULT ignores `column_ready`. `position_sync` clears `fault` and goes to BLANK with target 0.
  - This protects the LEDs when the rotor stalls.
- **Undefined:** no FAULT state and no dwell counter, `fault` = 0 constant, `WATCHDOG_CYCLES` unused.

## Test plan

Parameters `NB_COLUMNS`=8, `BLANK_CYCLES`=4.

1. **Reset and first column:** reset, then one `column_ready` at cycle 10, `scan_dir`=0 → `mux_out`=0 through cycle 15, then 8'h01 and `column_index`=0.
2. **Forward wrap:** 9 `column_ready` strobes spaced 20 cycles apart, `scan_dir`=0 → sequence 01,02,…,80,01. Each change is preceded by exactly 4 zero cycles. `frame_done` pulses once, at the 80→01 transition.
3. **Reverse scan:** same as 2 with `scan_dir`=1 from column 0 → 01,80,40,…; `frame_done` pulses on the 0→7 wrap.
4. **Sync priority:** at column 5, assert `position_sync` and `column_ready` together → 4 zero cycles, then 8'h01, `overrun`=0, no `frame_done`.
5. **Overrun:** `column_ready` 2 cycles after a previous one → second strobe ignored, `overrun`=1 until the next `position_sync`.
6. **Watchdog (`COLUMN_SCANNER_WATCHDOG_EN`, `WATCHDOG_CYCLES`=100):** no strobe for 100 cycles in ACTIVE → `mux_out`=0, `fault`=1; `column_ready` has no effect; `position_sync` → `fault`=0, 8'h01 after 4 cycles.

Source files
------------

// File: rtl/column_scanner.sv
// One-hot column scanner with guaranteed blanking dead time, scan direction and sync restart.
// Define COLUMN_SCANNER_WATCHDOG_EN to add the stall watchdog and FAULT state.
module column_scanner #(
    parameter int unsigned NB_COLUMNS      = 8,
    parameter int unsigned BLANK_CYCLES    = 4,
    parameter int unsigned WATCHDOG_CYCLES = 2000000,
    localparam int unsigned IdxW = (NB_COLUMNS > 2) ? $clog2(NB_COLUMNS) : 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  column_ready,
    input  logic                  position_sync,
    input  logic                  scan_dir,
    output logic [NB_COLUMNS-1:0] mux_out,
    output logic [IdxW-1:0]       column_index,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  fault
);

    localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [IdxW-1:0]       LastIdx   = IdxW'(NB_COLUMNS - 1);
    localparam logic [BlankW-1:0]     BlankLoad = BlankW'(BLANK_CYCLES - 1);
    localparam logic [NB_COLUMNS-1:0] OneHot0   = NB_COLUMNS'(1);

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StActive
`ifdef COLUMN_SCANNER_WATCHDOG_EN
        , StFault
`endif
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   target_q;
    logic [BlankW-1:0] blank_cnt_q;
    logic              ready_q;
    logic              sync_q;
    logic              dir_q;
    logic [IdxW-1:0]   next_idx;
    logic              wrap;

`ifdef COLUMN_SCANNER_WATCHDOG_EN
    localparam int unsigned WdW = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(WATCHDOG_CYCLES - 1);
    logic [WdW-1:0] dwell_q;
    logic           fault_q;
    assign fault = fault_q;
`else
    logic unused_wd;
    assign unused_wd = ^WATCHDOG_CYCLES;
    assign fault     = 1'b0;
`endif

    // Explicit wrap: NB_COLUMNS need not be a power of two.
    always_comb begin
        next_idx = column_index;
        wrap     = 1'b0;
        if (!dir_q) begin
            if (column_index == LastIdx) begin
                next_idx = '0;
                wrap     = 1'b1;
            end else begin
                next_idx = column_index + 1'b1;
            end
        end else begin
            if (column_index == '0) begin
                next_idx = LastIdx;
                wrap     = 1'b1;
            end else begin
                next_idx = column_index - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            target_q     <= '0;
            blank_cnt_q  <= '0;
            ready_q      <= 1'b0;
            sync_q       <= 1'b0;
            dir_q        <= 1'b0;
            mux_out      <= '0;
            column_index <= '0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
`ifdef COLUMN_SCANNER_WATCHDOG_EN
            dwell_q      <= '0;
            fault_q      <= 1'b0;
`endif
        end else begin
            ready_q    <= column_ready;
            sync_q     <= position_sync;
            dir_q      <= scan_dir;
            frame_done <= 1'b0;
            if (sync_q) begin
                overrun <= 1'b0;
`ifdef COLUMN_SCANNER_WATCHDOG_EN
                fault_q <= 1'b0;
`endif
            end

            case (state_q)
                StIdle: begin
                    if (sync_q || ready_q) begin
                        target_q    <= '0;
                        blank_cnt_q <= BlankLoad;
                        state_q     <= StBlank;
                    end
                end
                StBlank: begin
                    if (sync_q) begin
                        // Restart the full dead time toward column 0.
                        target_q    <= '0;
                        blank_cnt_q <= BlankLoad;
                    end else begin
                        if (ready_q) begin
                            overrun <= 1'b1;
                        end
                        if (blank_cnt_q == '0) begin
                            mux_out      <= OneHot0 << target_q;
                            column_index <= target_q;
                            state_q      <= StActive;
`ifdef COLUMN_SCANNER_WATCHDOG_EN
                            dwell_q      <= '0;
`endif
                        end else begin
                            blank_cnt_q <= blank_cnt_q - 1'b1;
                        end
                    end
                end
                StActive: begin
                    if (sync_q) begin
                        target_q    <= '0;
                        mux_out     <= '0;
                        blank_cnt_q <= BlankLoad;
                        state_q     <= StBlank;
                    end else if (ready_q) begin
                        target_q    <= next_idx;
                        frame_done  <= wrap;
                        mux_out     <= '0;
                        blank_cnt_q <= BlankLoad;
                        state_q     <= StBlank;
                    end
`ifdef COLUMN_SCANNER_WATCHDOG_EN
                    else if (dwell_q == WdLast) begin
                        mux_out <= '0;
                        fault_q <= 1'b1;
                        state_q <= StFault;
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
`endif
                end
`ifdef COLUMN_SCANNER_WATCHDOG_EN
                StFault: begin
                    if (sync_q) begin
                        target_q    <= '0;
                        blank_cnt_q <= BlankLoad;
                        state_q     <= StBlank;
                    end
                end
`endif
                default: begin
                    mux_out <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_column_scanner.sv
// Directed bench for column_scanner: expected columns queued at each strobe, checked when lit.
// Watchdog steps run only when COLUMN_SCANNER_WATCHDOG_EN is defined.
module tb_column_scanner;

    localparam int NC = 8;
    localparam int BC = 4;
    localparam int WD = 100;

    logic       clk = 1'b0;
    logic       nrst;
    logic       column_ready;
    logic       position_sync;
    logic       scan_dir;
    logic [7:0] mux_out;
    logic [2:0] column_index;
    logic       frame_done;
    logic       overrun;
    logic       fault;

    always #5 clk = ~clk;

    column_scanner #(
        .NB_COLUMNS     (NC),
        .BLANK_CYCLES   (BC),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .column_ready (column_ready),
        .position_sync(position_sync),
        .scan_dir     (scan_dir),
        .mux_out      (mux_out),
        .column_index (column_index),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .fault        (fault)
    );

    typedef struct {
        logic [7:0] mux;
        logic [2:0] idx;
        int         lit_cyc;
        bit         fd;
        bit         chk_blank;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         zero_run = 0;
    int         fd_n     = 0;
    int         fd_at    = 0;
    logic [7:0] prev_mux = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // Monitor: pops the scoreboard whenever a new column lights.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (nrst) begin
                check("onehot0", 32'($onehot0(mux_out)), 32'd1);
                if (frame_done) begin
                    fd_n++;
                    fd_at = cyc;
                end
                if (mux_out != prev_mux && mux_out != 8'h00) begin
                    if (sb.size() == 0) begin
                        check("unexpected_lit", 32'(mux_out), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("mux_out", 32'(mux_out), 32'(e.mux));
                        check("column_index", 32'(column_index), 32'(e.idx));
                        check("lit_cycle", cyc, e.lit_cyc);
                        if (e.chk_blank) check("dead_time", zero_run, BC);
                        check("frame_done_count", fd_n, 32'(e.fd));
                        if (e.fd) check("frame_done_cycle", fd_at, e.lit_cyc - BC);
                    end
                    fd_n = 0;
                end
                zero_run = (mux_out == 8'h00) ? zero_run + 1 : 0;
            end else begin
                zero_run = 0;
                fd_n     = 0;
            end
            prev_mux = mux_out;
        end
    end

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle strobe; when push is set, queue the column it should light.
    task automatic strobe(input bit r, input bit s, input bit d, input bit push,
                          input logic [2:0] idx, input bit fd, input bit cb);
        logic [7:0] m;
        @(negedge clk);
        column_ready  = r;
        position_sync = s;
        scan_dir      = d;
        m = 8'h01 << idx;
        if (push) sb.push_back('{mux: m, idx: idx, lit_cyc: cyc + 2 + BC, fd: fd, chk_blank: cb});
        @(negedge clk);
        column_ready  = 1'b0;
        position_sync = 1'b0;
    endtask

    initial begin
        int lit;
        nrst          = 1'b0;
        column_ready  = 1'b0;
        position_sync = 1'b0;
        scan_dir      = 1'b0;
        gap(3);
        check("rst_mux_out", 32'(mux_out), 32'd0);
        check("rst_column_index", 32'(column_index), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        nrst = 1'b1;
        gap(6);

        // First column from IDLE, then forward wrap.
        strobe(1, 0, 0, 1, 3'd0, 0, 0);
        gap(18);
        for (int i = 1; i <= 8; i++) begin
            strobe(1, 0, 0, 1, 3'(i % 8), (i == 8), 1);
            gap(18);
        end

        // Reverse scan from column 0.
        for (int i = 1; i <= 8; i++) begin
            strobe(1, 0, 1, 1, 3'((8 - i) % 8), (i == 1), 1);
            gap(18);
        end

        // Advance to column 5, then simultaneous sync and ready.
        for (int i = 1; i <= 5; i++) begin
            strobe(1, 0, 0, 1, 3'(i), 0, 1);
            gap(18);
        end
        strobe(1, 1, 0, 1, 3'd0, 0, 1);
        gap(18);
        check("sync_prio_overrun", 32'(overrun), 32'd0);

        // Overrun: second ready two cycles after the first is dropped.
        strobe(1, 0, 0, 1, 3'd1, 0, 1);
        strobe(1, 0, 0, 0, 3'd0, 0, 0);
        gap(18);
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_index", 32'(column_index), 32'd1);
        strobe(1, 0, 0, 1, 3'd2, 0, 1);
        gap(18);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Sync during blanking restarts the dead time toward column 0 and clears overrun.
        strobe(1, 0, 0, 0, 3'd0, 0, 0);
        strobe(0, 1, 0, 1, 3'd0, 0, 0);
        gap(18);
        check("overrun_cleared", 32'(overrun), 32'd0);

        // Asynchronous reset while lit.
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("async_rst_mux_out", 32'(mux_out), 32'd0);
        check("async_rst_index", 32'(column_index), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        gap(3);
        strobe(1, 0, 0, 1, 3'd0, 0, 0);
        gap(18);

`ifdef COLUMN_SCANNER_WATCHDOG_EN
        strobe(1, 0, 0, 1, 3'd1, 0, 1);
        lit = cyc + 1 + BC;
        gap(lit + 95 - cyc);
        check("wd_still_lit", 32'(mux_out), 32'h02);
        check("wd_no_fault_yet", 32'(fault), 32'd0);
        gap(10);
        check("wd_mux_off", 32'(mux_out), 32'd0);
        check("wd_fault_set", 32'(fault), 32'd1);
        strobe(1, 0, 0, 0, 3'd0, 0, 0);
        gap(10);
        check("wd_ready_ignored", 32'(mux_out), 32'd0);
        check("wd_fault_held", 32'(fault), 32'd1);
        strobe(0, 1, 0, 1, 3'd0, 0, 0);
        gap(18);
        check("wd_fault_cleared", 32'(fault), 32'd0);
`else
        lit = 0;
        check("fault_tied_low", 32'(fault), 32'(lit));
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
